cdb_arbiter: RTL and testbench



---
 rtl/cdb_arbiter_pkg.sv | 19 +
 rtl/cdb_arbiter_if.sv | 29 ++
 rtl/cdb_rr_picker.sv | 35 +++
 rtl/cdb_arbiter.sv | 114 +++++++++++
 tb/tb_cdb_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: functional-unit source indices and broadcast field widths.
// Used by the arbiter, control unit and register file.
package cdb_arbiter_pkg;

    localparam int CDB_SRC_W = 3;
    localparam int CDB_RD_W  = 5;

    typedef enum logic [CDB_SRC_W-1:0] {
        SRC_ALU1 = 3'd0,
        SRC_ALU2 = 3'd1,
        SRC_ALU3 = 3'd2,
        SRC_MEM1 = 3'd3,
        SRC_MEM2 = 3'd4,
        SRC_MUL  = 3'd5,
        SRC_DIV  = 3'd6,
        SRC_JUMP = 3'd7
    } cdb_src_e;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result-source to CDB bus: per-FU request lanes in, single broadcast out.
// The arbiter takes the slave side; functional units / the bench take master.
interface cdb_arbiter_if #(
    parameter int NUM_SRC = 8,
    parameter int DATA_W  = 32
);
    import cdb_arbiter_pkg::*;

    logic                        flush;
    logic [NUM_SRC-1:0]          req_valid;
    logic [NUM_SRC*CDB_RD_W-1:0] req_rd;
    logic [NUM_SRC*DATA_W-1:0]   req_data;
    logic [NUM_SRC-1:0]          req_ready;
    logic                        cdb_valid;
    logic [CDB_SRC_W-1:0]        cdb_src;
    logic [CDB_RD_W-1:0]         cdb_rd;
    logic [DATA_W-1:0]           cdb_data;

    modport master (
        output flush, req_valid, req_rd, req_data,
        input  req_ready, cdb_valid, cdb_src, cdb_rd, cdb_data
    );

    modport slave (
        input  flush, req_valid, req_rd, req_data,
        output req_ready, cdb_valid, cdb_src, cdb_rd, cdb_data
    );

endinterface

// File: rtl/cdb_rr_picker.sv
// One-hot pick of the first set request at or after ptr, wrapping modulo N.
// With ptr tied to zero this degenerates to lowest-index-wins.
module cdb_rr_picker #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] j;

    assign gnt_any = |req;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        sum     = '0;
        j       = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
            j = sum[IDX_W-1:0];
            if (req[j] && (gnt == '0)) begin
                gnt[j]  = 1'b1;
                gnt_idx = j;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding buffer per FU, one broadcast per cycle.
// Define CDB_ROUND_ROBIN_EN for rotating priority; otherwise lowest source index wins.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int DATA_W  = 32
) (
    input  logic       clk,
    input  logic       rst,
    cdb_arbiter_if.slave bus
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]                full_q, full_d;
    logic [NUM_SRC-1:0][CDB_RD_W-1:0]  rd_q, rd_d;
    logic [NUM_SRC-1:0][DATA_W-1:0]    data_q, data_d;
    logic [NUM_SRC-1:0]                grant;
    logic [NUM_SRC-1:0]                req_ready;
    logic [IDX_W-1:0]                  gnt_idx;
    logic [IDX_W-1:0]                  pick_ptr;
    logic                              gnt_any;

    logic                 cdb_valid_q, cdb_valid_d;
    logic [CDB_SRC_W-1:0] cdb_src_q, cdb_src_d;
    logic [CDB_RD_W-1:0]  cdb_rd_q, cdb_rd_d;
    logic [DATA_W-1:0]    cdb_data_q, cdb_data_d;

    cdb_rr_picker #(.N(NUM_SRC), .IDX_W(IDX_W)) u_pick (
        .req     (full_q),
        .ptr     (pick_ptr),
        .gnt     (grant),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

`ifdef CDB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any && !bus.flush)
            ptr_d = (gnt_idx == IDX_W'(NUM_SRC-1)) ? '0 : gnt_idx + IDX_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    assign pick_ptr = ptr_q;
`else
    assign pick_ptr = '0;
`endif

    // A granted buffer drains this cycle, so it may accept a new result in parallel.
    assign req_ready     = ~full_q | grant;
    assign bus.req_ready = req_ready;

    always_comb begin
        full_d      = full_q & ~grant;
        rd_d        = rd_q;
        data_d      = data_q;
        cdb_valid_d = 1'b0;
        cdb_src_d   = cdb_src_q;
        cdb_rd_d    = cdb_rd_q;
        cdb_data_d  = cdb_data_q;

        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.req_valid[i] && req_ready[i]) begin
                // rd==0 writes nothing architecturally: consume it, never broadcast.
                full_d[i] = (bus.req_rd[CDB_RD_W*i +: CDB_RD_W] != '0);
                rd_d[i]   = bus.req_rd[CDB_RD_W*i +: CDB_RD_W];
                data_d[i] = bus.req_data[DATA_W*i +: DATA_W];
            end
        end

        if (gnt_any && !bus.flush) begin
            cdb_valid_d = 1'b1;
            cdb_src_d   = CDB_SRC_W'(gnt_idx);
            cdb_rd_d    = rd_q[gnt_idx];
            cdb_data_d  = data_q[gnt_idx];
        end

        if (bus.flush) full_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q      <= '0;
            rd_q        <= '0;
            data_q      <= '0;
            cdb_valid_q <= 1'b0;
            cdb_src_q   <= '0;
            cdb_rd_q    <= '0;
            cdb_data_q  <= '0;
        end else begin
            full_q      <= full_d;
            rd_q        <= rd_d;
            data_q      <= data_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_src_q   <= cdb_src_d;
            cdb_rd_q    <= cdb_rd_d;
            cdb_data_q  <= cdb_data_d;
        end
    end

    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_src   = cdb_src_q;
    assign bus.cdb_rd    = cdb_rd_q;
    assign bus.cdb_data  = cdb_data_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed vectors push expected broadcasts,
// a negedge monitor pops and compares every cdb_valid pulse.
module tb_cdb_arbiter;

    localparam int NS = 8;
    localparam int DW = 32;
`ifdef CDB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic [2:0]  src;
        logic [4:0]  rd;
        logic [31:0] data;
    } bc_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;
    int bc_count = 0;

    bc_t   exp_q[$];
    item_t fu_q[NS][$];

    cdb_arbiter_if #(.NUM_SRC(NS), .DATA_W(DW)) bus ();

    cdb_arbiter #(.NUM_SRC(NS), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int s, input logic [4:0] rd, input logic [31:0] d);
        bc_t e;
        e.src  = 3'(s);
        e.rd   = rd;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_fu(input int s, input logic [4:0] rd, input logic [31:0] d);
        item_t it;
        it.rd   = rd;
        it.data = d;
        fu_q[s].push_back(it);
    endtask

    task automatic set_req(input int s, input logic [4:0] rd, input logic [31:0] d);
        bus.req_valid[s]         = 1'b1;
        bus.req_rd[5*s +: 5]     = rd;
        bus.req_data[DW*s +: DW] = d;
    endtask

    task automatic clear_req();
        bus.req_valid = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.flush = 1'b0;
        clear_req();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Functional-unit model: present queue heads, pop on a sampled handshake.
    task automatic run_fu(input int max_cycles);
        int cyc;
        int pending;
        logic [NS-1:0] xfer;
        cyc = 0;
        pending = 0;
        for (int s = 0; s < NS; s++) pending += fu_q[s].size();
        while (pending > 0 && cyc < max_cycles) begin
            clear_req();
            for (int s = 0; s < NS; s++)
                if (fu_q[s].size() > 0) set_req(s, fu_q[s][0].rd, fu_q[s][0].data);
            @(negedge clk);
            xfer = bus.req_valid & bus.req_ready;
            @(posedge clk);
            #1;
            for (int s = 0; s < NS; s++)
                if (xfer[s]) void'(fu_q[s].pop_front());
            pending = 0;
            for (int s = 0; s < NS; s++) pending += fu_q[s].size();
            cyc++;
        end
        clear_req();
        chk("fu_drain_pending", 64'(pending), 64'd0);
    endtask

    task automatic wait_drain(input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < max_cycles) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("sb_drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        bc_t e;
        if (!rst && bus.cdb_valid) begin
            bc_count++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL cdb_unexpected actual src=%0d rd=%0d data=%0h required=no broadcast",
                         bus.cdb_src, bus.cdb_rd, bus.cdb_data);
            end else begin
                e = exp_q.pop_front();
                chk("cdb_bcast", 64'({bus.cdb_src, bus.cdb_rd, bus.cdb_data}), 64'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        bus.flush     = 1'b0;
        bus.req_valid = '0;
        bus.req_rd    = '0;
        bus.req_data  = '0;

        // Reset state
        #1;
        chk("rst_cdb_fields", 64'({bus.cdb_valid, bus.cdb_src, bus.cdb_rd, bus.cdb_data}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 64'(bus.req_ready), 64'hFF);

        // Single MUL result, 2-edge latency, one-cycle pulse
        @(posedge clk); #1;
        set_req(5, 5'd3, 32'h12345678);
        push_exp(5, 5'd3, 32'h12345678);
        @(negedge clk);
        chk("single_ready", 64'(bus.req_ready[5]), 64'd1);
        @(posedge clk); #1;
        clear_req();
        chk("single_e0_valid", 64'(bus.cdb_valid), 64'd0);
        @(posedge clk); #1;
        chk("single_e1", 64'({bus.cdb_valid, bus.cdb_src, bus.cdb_rd, bus.cdb_data}),
            64'({1'b1, 3'd5, 5'd3, 32'h12345678}));
        @(posedge clk); #1;
        chk("single_e2_valid", 64'(bus.cdb_valid), 64'd0);
        chk("single_hold", 64'({bus.cdb_src, bus.cdb_rd, bus.cdb_data}),
            64'({3'd5, 5'd3, 32'h12345678}));

        // All eight sources at once
        do_reset();
        @(posedge clk); #1;
        for (int s = 0; s < NS; s++) begin
            set_req(s, 5'(s + 1), 32'(s));
            push_exp(s, 5'(s + 1), 32'(s));
        end
        @(negedge clk);
        chk("all8_ready_pre", 64'(bus.req_ready), 64'hFF);
        @(posedge clk); #1;
        clear_req();
        @(negedge clk);
        chk("all8_ready_wait", 64'(bus.req_ready), 64'h01);
        for (int k = 0; k < NS; k++) begin
            @(negedge clk);
            chk("all8_b2b_valid", 64'(bus.cdb_valid), 64'd1);
        end
        @(negedge clk);
        chk("all8_idle_valid", 64'(bus.cdb_valid), 64'd0);
        wait_drain(5);

        // Source 2 requests every cycle with source 3 pending
        do_reset();
        for (int k = 0; k < 4; k++) begin
            push_fu(2, 5'd2, 32'h200 + 32'(k));
            push_fu(3, 5'd3, 32'h300 + 32'(k));
        end
        if (RR) begin
            for (int k = 0; k < 4; k++) begin
                push_exp(2, 5'd2, 32'h200 + 32'(k));
                push_exp(3, 5'd3, 32'h300 + 32'(k));
            end
        end else begin
            for (int k = 0; k < 4; k++) push_exp(2, 5'd2, 32'h200 + 32'(k));
            for (int k = 0; k < 4; k++) push_exp(3, 5'd3, 32'h300 + 32'(k));
        end
        run_fu(40);
        wait_drain(20);

        // JUMP with rd=0 is consumed silently
        do_reset();
        b0 = bc_count;
        @(posedge clk); #1;
        set_req(7, 5'd0, 32'hDEAD);
        @(negedge clk);
        chk("rd0_ready", 64'(bus.req_ready[7]), 64'd1);
        @(posedge clk); #1;
        set_req(7, 5'd9, 32'hBEEF);
        push_exp(7, 5'd9, 32'hBEEF);
        @(negedge clk);
        chk("rd0_next_ready", 64'(bus.req_ready[7]), 64'd1);
        @(posedge clk); #1;
        clear_req();
        chk("rd0_no_pulse", 64'(bus.cdb_valid), 64'd0);
        @(posedge clk); #1;
        chk("rd0_next_bcast", 64'({bus.cdb_valid, bus.cdb_src, bus.cdb_rd}),
            64'({1'b1, 3'd7, 5'd9}));
        repeat (3) @(posedge clk);
        #1;
        chk("rd0_bcast_count", 64'(bc_count - b0), 64'd1);

        // Flush with three buffers full
        do_reset();
        b0 = bc_count;
        @(posedge clk); #1;
        set_req(1, 5'd11, 32'h111);
        set_req(4, 5'd14, 32'h444);
        set_req(6, 5'd16, 32'h666);
        @(posedge clk); #1;
        clear_req();
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_ready_during", 64'(bus.req_ready), 64'hAF);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_valid", 64'(bus.cdb_valid), 64'd0);
        chk("flush_ready", 64'(bus.req_ready), 64'hFF);
        repeat (6) @(posedge clk);
        #1;
        chk("flush_no_bcast", 64'(bc_count - b0), 64'd0);

        // Reset mid-broadcast with two buffers still full
        do_reset();
        @(posedge clk); #1;
        set_req(0, 5'd5, 32'hAAAA);
        set_req(1, 5'd6, 32'hBBBB);
        set_req(2, 5'd7, 32'hCCCC);
        push_exp(0, 5'd5, 32'hAAAA);
        @(posedge clk); #1;
        clear_req();
        @(posedge clk); #1;
        chk("rstmid_pre_valid", 64'(bus.cdb_valid), 64'd1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rstmid_outputs", 64'({bus.cdb_valid, bus.cdb_src, bus.cdb_rd, bus.cdb_data}), 64'd0);
        b0 = bc_count;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_ready", 64'(bus.req_ready), 64'hFF);
        repeat (5) @(posedge clk);
        #1;
        chk("rstmid_no_stale", 64'(bc_count - b0), 64'd0);
        chk("final_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
